// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared pipeline types: control bundle, NOP control, $zero
//               specifier and the ID/EX hazard FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       MemToReg;
        logic       RegDst;
        logic       ALUSrc;
        logic [1:0] ALUOp;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;
    localparam int    REG_ZERO = 0;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard equation between the
//               instruction in EX (a load) and the instruction in ID.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipeline_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_uses_rt,
    output logic              o_lu
);

    logic w_ex_load;
    logic w_rs_match;
    logic w_rt_match;

    // A load into $zero produces nothing to wait for.
    assign w_ex_load  = i_ex_valid & i_ex_mem_read & (i_ex_rt != REG_AW'(REG_ZERO));
    assign w_rs_match = (i_ex_rt == i_id_rs);
    assign w_rt_match = i_id_uses_rt & (i_ex_rt == i_id_rt);
    assign o_lu       = w_ex_load & i_id_valid & (w_rs_match | w_rt_match);

endmodule
`default_nettype wire

// File: rtl/id_ex_hazard_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_hazard_reg
// Description : MIPS ID/EX pipeline register with load-use stall, bubble
//               insertion, flush and external hold. Optional HAZ_STATS_EN
//               adds saturating stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_hazard_reg
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ID_valid,
    input  logic [REG_AW-1:0] ID_rs,
    input  logic [REG_AW-1:0] ID_rt,
    input  logic [REG_AW-1:0] ID_rd,
    input  logic              ID_uses_rt,
    input  logic [DATA_W-1:0] ID_read_data1,
    input  logic [DATA_W-1:0] ID_read_data2,
    input  logic [DATA_W-1:0] ID_imm,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemToReg,
    input  logic              ID_RegDst,
    input  logic              ID_ALUSrc,
    input  logic [1:0]        ID_ALUOp,
    input  logic              flush,
    input  logic              hold,
    output logic              EX_valid,
    output logic [REG_AW-1:0] EX_rs,
    output logic [REG_AW-1:0] EX_rt,
    output logic [REG_AW-1:0] EX_rd,
    output logic [DATA_W-1:0] EX_read_data1,
    output logic [DATA_W-1:0] EX_read_data2,
    output logic [DATA_W-1:0] EX_imm,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_MemToReg,
    output logic              EX_RegDst,
    output logic              EX_ALUSrc,
    output logic [1:0]        EX_ALUOp,
`ifdef HAZ_STATS_EN
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count,
`endif
    output logic              PCWrite,
    output logic              IFID_Write,
    output logic              bubble
);

    logic              ex_valid_q, ex_valid_d;
    logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] ex_data1_q, ex_data1_d;
    logic [DATA_W-1:0] ex_data2_q, ex_data2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    state_t            state_q, state_d;
    ctrl_t             w_id_ctrl;
    logic              w_lu;
    logic              w_lu_bubble;

    assign w_id_ctrl = '{RegWrite: ID_RegWrite, MemRead: ID_MemRead, MemWrite: ID_MemWrite,
                         MemToReg: ID_MemToReg, RegDst: ID_RegDst, ALUSrc: ID_ALUSrc,
                         ALUOp: ID_ALUOp};

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_lu (
        .i_ex_valid    (ex_valid_q),
        .i_ex_mem_read (ex_ctrl_q.MemRead),
        .i_ex_rt       (ex_rt_q),
        .i_id_valid    (ID_valid),
        .i_id_rs       (ID_rs),
        .i_id_rt       (ID_rt),
        .i_id_uses_rt  (ID_uses_rt),
        .o_lu          (w_lu)
    );

    assign w_lu_bubble = w_lu & ~hold & ~flush;

    // On flush the upstream squash belongs to IF/ID, so the front end keeps moving.
    assign PCWrite    = ~rst_n | ~(hold | (w_lu & ~flush));
    assign IFID_Write = PCWrite;
    assign bubble     = rst_n & (flush | w_lu_bubble);

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        ex_rd_d    = ex_rd_q;
        ex_data1_d = ex_data1_q;
        ex_data2_d = ex_data2_q;
        ex_imm_d   = ex_imm_q;
        ex_ctrl_d  = ex_ctrl_q;
        if (flush || (!hold && w_lu)) begin
            ex_valid_d = 1'b0;
            ex_rs_d    = '0;
            ex_rt_d    = '0;
            ex_rd_d    = '0;
            ex_data1_d = '0;
            ex_data2_d = '0;
            ex_imm_d   = '0;
            ex_ctrl_d  = CTRL_NOP;
        end else if (!hold) begin
            ex_valid_d = ID_valid;
            ex_rs_d    = ID_rs;
            ex_rt_d    = ID_rt;
            ex_rd_d    = ID_rd;
            ex_data1_d = ID_read_data1;
            ex_data2_d = ID_read_data2;
            ex_imm_d   = ID_imm;
            ex_ctrl_d  = w_id_ctrl;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (w_lu_bubble) state_d = STALL;
            STALL:   if (!hold)       state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            ex_data1_q <= '0;
            ex_data2_q <= '0;
            ex_imm_q   <= '0;
            ex_ctrl_q  <= CTRL_NOP;
            state_q    <= RUN;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
            ex_data1_q <= ex_data1_d;
            ex_data2_q <= ex_data2_d;
            ex_imm_q   <= ex_imm_d;
            ex_ctrl_q  <= ex_ctrl_d;
            state_q    <= state_d;
        end
    end

    // The bubble sitting in EX has MemRead=0, so a hazard here means corrupted state.
    a_no_lu_in_stall: assert property (@(posedge clk) disable iff (!rst_n)
                                       (state_q == STALL) |-> !w_lu);

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_lu_bubble && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush && (flush_cnt_q != '1))       flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

    assign EX_valid      = ex_valid_q;
    assign EX_rs         = ex_rs_q;
    assign EX_rt         = ex_rt_q;
    assign EX_rd         = ex_rd_q;
    assign EX_read_data1 = ex_data1_q;
    assign EX_read_data2 = ex_data2_q;
    assign EX_imm        = ex_imm_q;
    assign EX_RegWrite   = ex_ctrl_q.RegWrite;
    assign EX_MemRead    = ex_ctrl_q.MemRead;
    assign EX_MemWrite   = ex_ctrl_q.MemWrite;
    assign EX_MemToReg   = ex_ctrl_q.MemToReg;
    assign EX_RegDst     = ex_ctrl_q.RegDst;
    assign EX_ALUSrc     = ex_ctrl_q.ALUSrc;
    assign EX_ALUOp      = ex_ctrl_q.ALUOp;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_hazard_reg
// Description : Self-checking bench for id_ex_hazard_reg (vector table,
//               scoreboard of expected EX contents, reset corner sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_hazard_reg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // ctrl bit order: RegWrite MemRead MemWrite MemToReg RegDst ALUSrc ALUOp[1:0]
    localparam logic [7:0] C_LW   = 8'b1101_0100;
    localparam logic [7:0] C_ADD  = 8'b1000_1010;
    localparam logic [7:0] C_SW   = 8'b0010_0100;
    localparam logic [7:0] C_BEQ  = 8'b0000_0001;
    localparam logic [7:0] C_ADDI = 8'b1000_0100;

    logic clk = 1'b0;
    logic rst_n;
    logic ID_valid, ID_uses_rt;
    logic [REG_AW-1:0] ID_rs, ID_rt, ID_rd;
    logic [DATA_W-1:0] ID_read_data1, ID_read_data2, ID_imm;
    logic ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_RegDst, ID_ALUSrc;
    logic [1:0] ID_ALUOp;
    logic flush, hold;
    logic EX_valid;
    logic [REG_AW-1:0] EX_rs, EX_rt, EX_rd;
    logic [DATA_W-1:0] EX_read_data1, EX_read_data2, EX_imm;
    logic EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_RegDst, EX_ALUSrc;
    logic [1:0] EX_ALUOp;
    logic PCWrite, IFID_Write, bubble;
`ifdef HAZ_STATS_EN
    logic [31:0] stall_count, flush_count;
`endif

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
        .ID_uses_rt(ID_uses_rt),
        .ID_read_data1(ID_read_data1), .ID_read_data2(ID_read_data2), .ID_imm(ID_imm),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemToReg(ID_MemToReg), .ID_RegDst(ID_RegDst), .ID_ALUSrc(ID_ALUSrc),
        .ID_ALUOp(ID_ALUOp), .flush(flush), .hold(hold),
        .EX_valid(EX_valid), .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
        .EX_read_data1(EX_read_data1), .EX_read_data2(EX_read_data2), .EX_imm(EX_imm),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_MemToReg(EX_MemToReg), .EX_RegDst(EX_RegDst), .EX_ALUSrc(EX_ALUSrc),
        .EX_ALUOp(EX_ALUOp),
`ifdef HAZ_STATS_EN
        .stall_count(stall_count), .flush_count(flush_count),
`endif
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .bubble(bubble)
    );

    typedef struct packed {
        logic       valid;
        logic [4:0] rs, rt, rd;
        logic       uses_rt;
        logic [7:0] ctrl;
        logic       flush, hold;
        logic       exp_pcw, exp_bub;
    } vec_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2, imm;
        logic [7:0]  ctrl;
    } ex_t;

    ex_t  sbq[$];
    ex_t  m;
    ex_t  dut_ex;
    int   checks = 0;
    int   errors = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    vec_t tbl[20];

    assign dut_ex = {EX_valid, EX_rs, EX_rt, EX_rd, EX_read_data1, EX_read_data2, EX_imm,
                     EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_RegDst,
                     EX_ALUSrc, EX_ALUOp};

    function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic ur, input logic [7:0] c,
                                input logic fl, input logic hd, input logic pcw,
                                input logic bub);
        return '{valid: v, rs: rs, rt: rt, rd: rd, uses_rt: ur, ctrl: c,
                 flush: fl, hold: hd, exp_pcw: pcw, exp_bub: bub};
    endfunction

    function automatic logic lu_of(input ex_t e, input vec_t v);
        return e.valid & e.ctrl[6] & (e.rt != 5'd0) & v.valid &
               ((e.rt == v.rs) | (v.uses_rt & (e.rt == v.rt)));
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ID_valid   = v.valid;
        ID_rs      = v.rs;
        ID_rt      = v.rt;
        ID_rd      = v.rd;
        ID_uses_rt = v.uses_rt;
        {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_RegDst, ID_ALUSrc,
         ID_ALUOp} = v.ctrl;
        ID_read_data1 = $urandom;
        ID_read_data2 = $urandom;
        ID_imm        = $urandom;
        flush = v.flush;
        hold  = v.hold;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        ex_t  nxt;
        logic lu;
        @(negedge clk);
        drive(v);
        #1;
        lu = lu_of(m, v);
        chk({tag, ".PCWrite"},    128'(PCWrite),    128'(v.exp_pcw));
        chk({tag, ".IFID_Write"}, 128'(IFID_Write), 128'(v.exp_pcw));
        chk({tag, ".bubble"},     128'(bubble),     128'(v.exp_bub));
        if (v.flush)     nxt = '0;
        else if (v.hold) nxt = m;
        else if (lu)     nxt = '0;
        else nxt = {v.valid, v.rs, v.rt, v.rd, ID_read_data1, ID_read_data2, ID_imm, v.ctrl};
        if (lu && !v.hold && !v.flush) m_stall++;
        if (v.flush) m_flush++;
        sbq.push_back(nxt);
        m = nxt;
        @(posedge clk);
        #1;
        chk({tag, ".EX"}, 128'(dut_ex), 128'(sbq.pop_front()));
    endtask

    task automatic chk_stats(input string tag);
`ifdef HAZ_STATS_EN
        chk({tag, ".stall_count"}, 128'(stall_count), 128'(m_stall));
        chk({tag, ".flush_count"}, 128'(flush_count), 128'(m_flush));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        tbl[0]  = mk(1, 1, 8, 0, 0, C_LW,   0, 0, 1, 0);
        tbl[1]  = mk(1, 8, 2, 3, 1, C_ADD,  0, 0, 0, 1);  // load-use on rs
        tbl[2]  = mk(1, 8, 2, 3, 1, C_ADD,  0, 0, 1, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, C_LW,   0, 0, 1, 0);
        tbl[4]  = mk(1, 0, 5, 6, 1, C_ADD,  0, 0, 1, 0);  // $zero never stalls
        tbl[5]  = mk(1, 4, 9, 0, 0, C_LW,   0, 0, 1, 0);
        tbl[6]  = mk(1, 4, 9, 0, 0, C_ADDI, 0, 0, 1, 0);  // rt not a source
        tbl[7]  = mk(1, 2, 10, 0, 0, C_LW,  0, 0, 1, 0);
        tbl[8]  = mk(1, 3, 10, 0, 1, C_SW,  1, 0, 1, 1);  // flush over load-use
        tbl[9]  = mk(1, 2, 11, 0, 0, C_LW,  0, 0, 1, 0);
        tbl[10] = mk(0, 11, 1, 4, 1, C_ADD, 0, 0, 1, 0);  // ID not valid
        tbl[11] = mk(1, 2, 12, 0, 0, C_LW,  0, 0, 1, 0);
        tbl[12] = mk(1, 12, 3, 5, 1, C_ADD, 0, 1, 0, 0);  // hold beats load-use
        tbl[13] = mk(1, 6, 7, 8, 1, C_SW,   0, 1, 0, 0);
        tbl[14] = mk(1, 1, 1, 1, 0, C_BEQ,  0, 1, 0, 0);
        tbl[15] = mk(1, 1, 2, 13, 1, C_ADD, 0, 0, 1, 0);
        tbl[16] = mk(1, 5, 5, 5, 1, C_ADD,  1, 1, 0, 1);  // hold & flush
        tbl[17] = mk(1, 3, 7, 0, 0, C_LW,   0, 0, 1, 0);
        tbl[18] = mk(1, 1, 7, 0, 1, C_BEQ,  0, 0, 0, 1);  // load-use on rt
        tbl[19] = mk(1, 1, 7, 0, 1, C_BEQ,  0, 0, 1, 0);

        rst_n = 1'b1;
        m = '0;
        drive(mk(1, 3, 4, 5, 1, C_ADD, 0, 0, 1, 0));
        #3 rst_n = 1'b0;
        #1;
        chk("reset.EX",         128'(dut_ex),     128'(0));
        chk("reset.PCWrite",    128'(PCWrite),    128'(1));
        chk("reset.IFID_Write", 128'(IFID_Write), 128'(1));
        chk("reset.bubble",     128'(bubble),     128'(0));
        @(posedge clk);
        #1 chk("reset_edge.EX", 128'(dut_ex), 128'(0));
        chk_stats("reset");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 20; i++) run_vec(tbl[i], $sformatf("v%0d", i));
        chk_stats("table");

        // Reset asserted mid-cycle while the pipe is stalled and held.
        run_vec(mk(1, 0, 14, 0, 0, C_LW,  0, 0, 1, 0), "s0");
        run_vec(mk(1, 14, 0, 15, 0, C_ADD, 0, 0, 0, 1), "s1");
        @(negedge clk);
        drive(mk(1, 14, 0, 15, 0, C_ADD, 0, 1, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        m = '0;
        m_stall = 0;
        m_flush = 0;
        chk("midreset.EX",         128'(dut_ex),     128'(0));
        chk("midreset.PCWrite",    128'(PCWrite),    128'(1));
        chk("midreset.IFID_Write", 128'(IFID_Write), 128'(1));
        chk("midreset.bubble",     128'(bubble),     128'(0));
        chk_stats("midreset");
        @(negedge clk) rst_n = 1'b1;
        run_vec(mk(1, 14, 2, 15, 1, C_ADD, 0, 0, 1, 0), "r0");
        run_vec(mk(1, 6, 16, 0, 0, C_LW,   0, 0, 1, 0), "r1");
        run_vec(mk(1, 16, 0, 17, 0, C_ADD, 0, 0, 0, 1), "r2");
        run_vec(mk(1, 16, 0, 17, 0, C_ADD, 0, 0, 1, 0), "r3");
        run_vec(mk(1, 1, 2, 3, 1, C_ADD,   1, 0, 1, 1), "r4");
        chk_stats("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
